instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
Fetch stage directly upstream of the control unit. Holds the PC and issues word requests to instruction memory using a ready handshake. Captures each returned word into an IF/ID register whose opcode field drives the control unit's OP input. Resolves the next PC from PC+4, branch (BranchEn/BranchType/Zero), jump, and register-jump redirects, with stall and squash support.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded at reset (text segment base)
WIDTH, 32, instruction/address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall_i  in  1  hold IF/ID and PC (hazard from downstream)
branch_en_i  in  1  BranchEn from control, instruction in IF/ID
branch_type_i  in  1  BranchType: 1 beq, 0 bne
zero_i  in  1  comparator/ALU zero for the IF/ID branch
branch_offset_i  in  16  immediate of the IF/ID instruction
jump_i  in  1  Jump from control
jump_index_i  in  26  instr[25:0] of the IF/ID instruction
jr_i  in  1  register jump
jr_target_i  in  WIDTH  register value for jr
imem_req_o  out  1  fetch request
imem_addr_o  out  WIDTH  fetch address, bits[1:0] always 0
imem_rdata_i  in  WIDTH  returned instruction
imem_ready_i  in  1  rdata valid this cycle (only meaningful while req=1)
if_id_instr_o  out  WIDTH  registered instruction
if_id_pc4_o  out  WIDTH  registered PC+4 of that instruction
if_id_valid_o  out  1  IF/ID holds a live instruction
opcode_o  out  6  if_id_instr_o[31:26] when valid, else 6'h00
fetch_count_o  out  32  number of instructions delivered into IF/ID

Behaviour:
- Reset (reset=0, async): state IDLE, pc=RESET_PC, skid buffer empty, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_count=0. imem_req_o=0, imem_addr_o=RESET_PC.
- States: IDLE, FETCH, HOLD. IDLE->FETCH unconditionally on the first clock after reset release.
- FETCH: imem_req_o=1, imem_addr_o=pc held stable until ready. Zero-wait memory gives 1 instruction/cycle.
  - ready & !stall & !redirect: IF/ID<=(rdata, pc+4, valid=1); pc<=pc+4; fetch_count++.
  - ready & stall & !redirect: rdata and pc+4 go to the skid buffer; pc<=pc+4; go to HOLD. IF/ID unchanged.
  - !ready: if !stall, if_id_valid<=0 (bubble); if stall, IF/ID holds.
- HOLD: imem_req_o=0. When stall drops, IF/ID<=skid (valid=1), fetch_count++, go to FETCH.
- Redirect conditions (evaluated on the IF/ID contents, only when if_id_valid=1):
  - taken = branch_en_i & (branch_type_i ? zero_i : ~zero_i).
  - Priority: jr_i > jump_i > taken.
  - jr target = {jr_target_i[31:2],2'b00}.
  - jump target = {if_id_pc4[31:28], jump_index_i, 2'b00}.
  - branch target = if_id_pc4 + (sext(branch_offset_i)<<2), modulo 2^32.
- Redirect action, any state, overrides stall:
  - pc<=target; if_id_valid<=0; skid emptied; state<=FETCH.
  - A ready arriving in the same cycle is discarded and not counted.
  - No delay slot: the sequentially fetched word is squashed.
- Not-taken branch: no action, sequential flow continues.
- PC wraps 32'hFFFF_FFFC -> 0 with no error.
- fetch_count wraps at 2^32.
- Inputs with if_id_valid=0 are ignored, so control signals from a bubble (opcode 0) have no effect.
- Reset asserted mid-request: the request is dropped immediately; any later imem_ready_i is ignored until FETCH is re-entered.

Test Plan:
- Reset release, ready tied 1, memory returns addr as data -> req rises 1 cycle after release; IF/ID shows 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; fetch_count=3.
- Ready asserted every 3rd cycle -> imem_addr_o stays constant while waiting; if_id_valid pulses 1 only after each ready; no skipped or duplicated address.
- stall_i=1 for 4 cycles while a ready arrives -> state HOLD, req=0, IF/ID frozen. On release the buffered word enters IF/ID and the next address is prior+4.
- IF/ID holds beq at 0x00400010, branch_en=1, type=1, zero=1, offset=16'hFFFC -> next address 0x00400004 and the in-flight word is squashed. Same with zero=0 -> sequential 0x00400018 continues.
- jump_i=1, index=26'h0100010, jr_i=1 same cycle with jr_target=0x00400123 -> jr wins, fetch 0x00400120. Repeat with only jump_i -> fetch 0x00400040.
- Assert reset during FETCH with ready pending -> outputs return to reset values immediately, fetch_count=0, fetching resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : PC/fetch stage feeding an IF/ID register, with one-entry skid
//               buffer, stall hold and jr/jump/branch redirect with squash.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic             branch_type_i,
  input  logic             zero_i,
  input  logic [15:0]      branch_offset_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_index_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             imem_ready_i,
  output logic [WIDTH-1:0] if_id_instr_o,
  output logic [WIDTH-1:0] if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [5:0]       opcode_o,
  output logic [31:0]      fetch_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_skidInstr;
  logic [WIDTH-1:0] r_skidPc4;
  logic             r_skidValid;
  logic [WIDTH-1:0] r_ifIdInstr;
  logic [WIDTH-1:0] r_ifIdPc4;
  logic             r_ifIdValid;
  logic [31:0]      r_fetchCount;

  logic [WIDTH-1:0] w_pcPlus4;
  logic             w_taken;
  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_branchTarget;
  logic             w_captureMem;
  logic             w_captureSkid;
  logic             w_fillSkid;
  logic             w_bubble;
  logic             w_advancePc;

  assign w_pcPlus4      = r_pc + WIDTH'(4);
  assign w_taken        = branch_en_i & (branch_type_i ? zero_i : ~zero_i);
  // Control inputs only describe the IF/ID instruction, so a bubble never redirects.
  assign w_redirect     = r_ifIdValid & (jr_i | jump_i | w_taken);
  assign w_branchTarget = r_ifIdPc4 +
                          {{(WIDTH-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};

  always_comb begin
    w_target = w_branchTarget;
    if (jr_i) begin
      w_target = {jr_target_i[WIDTH-1:2], 2'b00};
    end else if (jump_i) begin
      w_target = {r_ifIdPc4[WIDTH-1:28], jump_index_i, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_captureMem  = 1'b0;
    w_captureSkid = 1'b0;
    w_fillSkid    = 1'b0;
    w_bubble      = 1'b0;
    w_advancePc   = 1'b0;
    if (w_redirect) begin
      w_nextState = FETCH;
    end else begin
      case (r_state)
        IDLE: w_nextState = FETCH;
        FETCH: begin
          if (imem_ready_i) begin
            w_advancePc = 1'b1;
            if (stall_i) begin
              w_fillSkid  = 1'b1;
              w_nextState = HOLD;
            end else begin
              w_captureMem = 1'b1;
            end
          end else if (!stall_i) begin
            w_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i && r_skidValid) begin
            w_captureSkid = 1'b1;
            w_nextState   = FETCH;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_PC;
      r_skidInstr  <= '0;
      r_skidPc4    <= '0;
      r_skidValid  <= 1'b0;
      r_ifIdInstr  <= '0;
      r_ifIdPc4    <= '0;
      r_ifIdValid  <= 1'b0;
      r_fetchCount <= '0;
    end else if (w_redirect) begin
      // Squash: any word returned this cycle belongs to the wrong path.
      r_pc        <= w_target;
      r_ifIdValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else begin
      if (w_advancePc) begin
        r_pc <= w_pcPlus4;
      end
      if (w_captureMem) begin
        r_ifIdInstr  <= imem_rdata_i;
        r_ifIdPc4    <= w_pcPlus4;
        r_ifIdValid  <= 1'b1;
        r_fetchCount <= r_fetchCount + 32'd1;
      end
      if (w_captureSkid) begin
        r_ifIdInstr  <= r_skidInstr;
        r_ifIdPc4    <= r_skidPc4;
        r_ifIdValid  <= 1'b1;
        r_skidValid  <= 1'b0;
        r_fetchCount <= r_fetchCount + 32'd1;
      end
      if (w_fillSkid) begin
        r_skidInstr <= imem_rdata_i;
        r_skidPc4   <= w_pcPlus4;
        r_skidValid <= 1'b1;
      end
      if (w_bubble) begin
        r_ifIdValid <= 1'b0;
      end
    end
  end

  assign imem_req_o    = (r_state == FETCH);
  assign imem_addr_o   = r_pc;
  assign if_id_instr_o = r_ifIdInstr;
  assign if_id_pc4_o   = r_ifIdPc4;
  assign if_id_valid_o = r_ifIdValid;
  assign opcode_o      = r_ifIdValid ? r_ifIdInstr[WIDTH-1:WIDTH-6] : 6'h00;
  assign fetch_count_o = r_fetchCount;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Scoreboard bench for instruction_fetch_stage; memory returns
//               address XOR a pattern as instruction data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        branch_en_i;
  logic        branch_type_i;
  logic        zero_i;
  logic [15:0] branch_offset_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ready_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [5:0]  opcode_o;
  logic [31:0] fetch_count_o;
  logic [31:0] dataXor;

  int checks = 0;
  int errors = 0;
  logic [31:0] expInstrQ[$];
  logic [31:0] expPc4Q[$];
  logic [31:0] lastCount = 32'd0;

  always #5 clk = ~clk;
  assign imem_rdata_i = imem_addr_o ^ dataXor;

  instruction_fetch_stage #(.WIDTH(32), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .branch_en_i(branch_en_i), .branch_type_i(branch_type_i), .zero_i(zero_i),
    .branch_offset_i(branch_offset_i), .jump_i(jump_i), .jump_index_i(jump_index_i),
    .jr_i(jr_i), .jr_target_i(jr_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_ready_i(imem_ready_i),
    .if_id_instr_o(if_id_instr_o), .if_id_pc4_o(if_id_pc4_o),
    .if_id_valid_o(if_id_valid_o), .opcode_o(opcode_o), .fetch_count_o(fetch_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] addr, input logic [31:0] pattern);
    expInstrQ.push_back(addr ^ pattern);
    expPc4Q.push_back(addr + 32'd4);
  endtask

  task automatic waitPc4(input logic [31:0] pc4);
    int n = 0;
    while (!(if_id_valid_o && if_id_pc4_o == pc4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_if_id_pc4", if_id_pc4_o, pc4);
  endtask

  task automatic clearCtrl();
    branch_en_i = 1'b0; branch_type_i = 1'b0; zero_i = 1'b0;
    jump_i = 1'b0; jr_i = 1'b0;
  endtask

  // Monitor: every increment of fetch_count is one delivery into IF/ID.
  always @(negedge clk) begin
    logic [31:0] ei, ep;
    if (!reset) begin
      lastCount = 32'd0;
    end else if (fetch_count_o != lastCount) begin
      lastCount = fetch_count_o;
      if (expInstrQ.size() == 0) begin
        check("unexpected_delivery", if_id_instr_o, 32'hxxxx_xxxx);
      end else begin
        ei = expInstrQ.pop_front();
        ep = expPc4Q.pop_front();
        check("deliver_instr", if_id_instr_o, ei);
        check("deliver_pc4", if_id_pc4_o, ep);
        check("deliver_valid", {31'b0, if_id_valid_o}, 32'd1);
        check("deliver_opcode", {26'b0, opcode_o}, {26'b0, ei[31:26]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b0; dataXor = 32'h0;
    branch_offset_i = 16'h0; jump_index_i = 26'h0; jr_target_i = 32'h0;
    clearCtrl();
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0040_0000);
    check("rst_valid", {31'b0, if_id_valid_o}, 32'd0);
    check("rst_instr", if_id_instr_o, 32'd0);
    check("rst_pc4", if_id_pc4_o, 32'd0);
    check("rst_count", fetch_count_o, 32'd0);
    check("rst_opcode", {26'b0, opcode_o}, 32'd0);

    // Zero-wait streaming
    pushExp(32'h0040_0000, 32'h0);
    pushExp(32'h0040_0004, 32'h0);
    pushExp(32'h0040_0008, 32'h0);
    imem_ready_i = 1'b1;
    reset = 1'b1;
    check("req_at_release", {31'b0, imem_req_o}, 32'd0);
    @(negedge clk);
    check("req_after_release", {31'b0, imem_req_o}, 32'd1);
    check("first_addr", imem_addr_o, 32'h0040_0000);
    repeat (3) @(negedge clk);
    imem_ready_i = 1'b0;
    check("count_after_stream", fetch_count_o, 32'd3);

    // Ready every third cycle; jr during bubbles must be ignored
    jr_target_i = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      pushExp(32'h0040_000C + 32'(k * 4), 32'h0);
      @(negedge clk);
      check("wait_addr_a", imem_addr_o, 32'h0040_000C + 32'(k * 4));
      check("wait_bubble_a", {31'b0, if_id_valid_o}, 32'd0);
      jr_i = 1'b1;
      @(negedge clk);
      check("wait_addr_b", imem_addr_o, 32'h0040_000C + 32'(k * 4));
      check("wait_bubble_b", {31'b0, if_id_valid_o}, 32'd0);
      imem_ready_i = 1'b1;
      @(negedge clk);
      imem_ready_i = 1'b0;
      jr_i = 1'b0;
    end
    check("count_after_slow", fetch_count_o, 32'd6);

    // Stall with a ready in flight: word goes to the skid buffer
    pushExp(32'h0040_0018, 32'h0);
    pushExp(32'h0040_001C, 32'h0);
    stall_i = 1'b1;
    imem_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_req", {31'b0, imem_req_o}, 32'd0);
      check("hold_instr", if_id_instr_o, 32'h0040_0014);
      check("hold_count", fetch_count_o, 32'd6);
    end
    stall_i = 1'b0;
    @(negedge clk);
    check("post_hold_addr", imem_addr_o, 32'h0040_001C);
    check("post_hold_req", {31'b0, imem_req_o}, 32'd1);
    @(negedge clk);
    check("post_hold_count", fetch_count_o, 32'd8);

    // Asynchronous reset in the middle of a FETCH with ready asserted
    #2 reset = 1'b0;
    #1;
    check("async_req", {31'b0, imem_req_o}, 32'd0);
    check("async_addr", imem_addr_o, 32'h0040_0000);
    check("async_valid", {31'b0, if_id_valid_o}, 32'd0);
    check("async_count", fetch_count_o, 32'd0);
    repeat (2) @(negedge clk);
    check("in_reset_count", fetch_count_o, 32'd0);
    check("in_reset_req", {31'b0, imem_req_o}, 32'd0);

    // Restart at RESET_PC with beq-like opcode (0x04) in the data
    dataXor = 32'h1000_0000;
    pushExp(32'h0040_0000, 32'h1000_0000);
    pushExp(32'h0040_0004, 32'h1000_0000);
    pushExp(32'h0040_0008, 32'h1000_0000);
    pushExp(32'h0040_000C, 32'h1000_0000);
    pushExp(32'h0040_0010, 32'h1000_0000);
    pushExp(32'h0040_0004, 32'h1000_0000);
    pushExp(32'h0040_0008, 32'h1000_0000);
    pushExp(32'h0040_000C, 32'h1000_0000);
    pushExp(32'h0040_0010, 32'h1000_0000);
    pushExp(32'h0040_0014, 32'h1000_0000);
    pushExp(32'h0040_0120, 32'h1000_0000);
    pushExp(32'h0040_0040, 32'h1000_0000);
    reset = 1'b1;

    // Taken beq at 0x00400010, offset -4 -> 0x00400004
    waitPc4(32'h0040_0014);
    branch_en_i = 1'b1; branch_type_i = 1'b1; zero_i = 1'b1; branch_offset_i = 16'hFFFC;
    @(negedge clk);
    clearCtrl();
    check("taken_addr", imem_addr_o, 32'h0040_0004);
    check("taken_squash", {31'b0, if_id_valid_o}, 32'd0);
    check("taken_count", fetch_count_o, 32'd5);

    // Same branch, zero=0: not taken
    waitPc4(32'h0040_0014);
    branch_en_i = 1'b1; branch_type_i = 1'b1; zero_i = 1'b0;
    @(negedge clk);
    clearCtrl();
    check("nottaken_addr", imem_addr_o, 32'h0040_0018);
    check("nottaken_pc4", if_id_pc4_o, 32'h0040_0018);

    // jr beats jump in the same cycle
    jump_i = 1'b1; jump_index_i = 26'h010_0010; jr_i = 1'b1; jr_target_i = 32'h0040_0123;
    @(negedge clk);
    clearCtrl();
    check("jr_addr", imem_addr_o, 32'h0040_0120);
    check("jr_squash", {31'b0, if_id_valid_o}, 32'd0);
    @(negedge clk);
    check("jr_landed_pc4", if_id_pc4_o, 32'h0040_0124);
    jump_i = 1'b1;
    @(negedge clk);
    clearCtrl();
    check("jump_addr", imem_addr_o, 32'h0040_0040);
    @(negedge clk);
    imem_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("final_count", fetch_count_o, 32'd12);
    check("scoreboard_drained", 32'(expInstrQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
